ms1205_rise_framer: RTL and testbench
=====================================

# ms1205_rise_framer

Downstream consumer of the MS1205 rise-edge TDC controller. Takes each rise-time strobe (`i_tdc_new_sig` / `i_rise_data`), applies zero-offset correction and range clamping, and tags the result with a quality flag and a per-revolution point index. It also frames points between revolution-start pulses and publishes per-frame statistics to the packet builder.

## Interface
- `MAX_PTS`, 1800: maximum points per revolution; index range 0..MAX_PTS-1.
- `IDX_W`, 12: index/count width; must satisfy 2^IDX_W > MAX_PTS.

- `i_clk_50m` in 1: single system clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_zero_sig` in 1: one-cycle revolution-start pulse (motor zero index).
- `i_tdc_new_sig` in 1: one-cycle sample strobe from the TDC controller.
- `i_rise_data` in 16: raw rise time. 16'hFFFF means no echo.
- `i_tdc_err_sig` in 1: TDC config error level.
- `i_zero_offset` in 16: calibration offset; latched at frame start.
- `i_dist_max` in 16: upper clamp; latched at frame start.
- `o_dist_data` out 16: corrected value.
- `o_dist_idx` out IDX_W: point index within the frame.
- `o_dist_flag` out 2: 00 ok, 01 no echo, 10 clamped, 11 TDC error.
- `o_dist_valid` out 1: one-cycle output strobe.
- `o_frame_done` out 1: one-cycle pulse at the end of each completed frame.
- `o_frame_pts` out IDX_W: point count of the last completed frame.
- `o_frame_miss` out 16: no-echo count of the last completed frame; saturates at 16'hFFFF.
- `o_frame_ovf` out 1: last frame contained more than MAX_PTS strobes.

## Operation
- **States:**
  - S_IDLE (one cycle after reset) → S_WAIT_ZERO.
  - S_WAIT_ZERO → S_RUN on `i_zero_sig`.
  - S_RUN stays in S_RUN.
- **S_WAIT_ZERO:** strobes are ignored; no `o_dist_valid` is produced.
- **Frame start (`i_zero_sig` in S_WAIT_ZERO or S_RUN):**
  - latch `i_zero_offset` and `i_dist_max`;
  - clear the point counter, miss counter and overflow flag.
- **Frame end (`i_zero_sig` in S_RUN):**
  - pulse `o_frame_done`;
  - copy the running point count, miss count and overflow flag into `o_frame_pts`, `o_frame_miss` and `o_frame_ovf`.
- **Accepted strobe (S_RUN, point count < MAX_PTS):**
  - `o_dist_idx` = current count, then count + 1.
  - Strobes beyond MAX_PTS are dropped (no output) and set the running overflow flag.
- **Correction, in priority order:**
  1. `i_tdc_err_sig`=1 → data 16'hFFFF, flag 11.
  2. raw = 16'hFFFF → data 16'hFFFF, flag 01; miss counter +1 (saturating).
  3. raw < offset → data 0, flag 00.
  4. raw − offset > dist_max → data = dist_max, flag 10.
  5. Otherwise → data = raw − offset, flag 00.
- **Arithmetic:** the subtraction is 17-bit with a borrow check; the comparison is unsigned.

## Timing
- **Reset values:** all outputs 0; state S_IDLE; latched offset 0; latched dist_max 16'hFFFF.
- **Latency:** strobe in cycle N → `o_dist_valid` in cycle N+2. Stage 1 registers raw/err/idx; stage 2 subtracts, compares and registers the outputs.
- **Throughput:** fully pipelined; a strobe is accepted every cycle.
- **Output hold:** `o_dist_data`, `o_dist_idx` and `o_dist_flag` hold until the next valid.
- **`o_frame_done`:** asserted in cycle N+1 after `i_zero_sig` in cycle N. `o_frame_*` update in the same cycle and hold until the next frame end.
- **Zero and strobe in the same cycle:** the strobe belongs to the new frame (idx 0, corrected with the new offset). The previous frame's statistics exclude it.
- **In-flight samples at a frame boundary:** samples in the pipeline keep their old index and old offset.
- **`i_rst` mid-frame:** next cycle all outputs are 0, the pipeline is flushed, state is S_IDLE. In-flight valids are lost.
- **No-echo counting:** counted at stage 1, so it is included in the frame that accepted the strobe.

## Structure
- Package `ms1205_pkg`:
  - flag codes `FLAG_OK`, `FLAG_NOECHO`, `FLAG_CLAMP`, `FLAG_TDCERR`;
  - state encoding;
  - `NO_ECHO` = 16'hFFFF.
- Sub-module `ms1205_rise_correct`: the two-stage correction pipeline (raw, err, idx, offset, max → data, flag, idx, valid).
- Top level: FSM, frame counters and statistics latching.

## Test plan
- **Basic correction:** zero pulse, offset 100, max 5000; strobes raw 1100, 50, 6000 → data 1000/0/5000, flags 00/00/10, idx 0/1/2, each valid 2 cycles after its strobe.
- **No echo and TDC error:** raw 16'hFFFF → data FFFF, flag 01, and `o_frame_miss`=1 at the next zero. With `i_tdc_err_sig`=1 and raw 500 → data FFFF, flag 11.
- **Overflow:** MAX_PTS=4, 6 strobes, then zero → 4 valids (idx 0..3), `o_frame_pts`=4, `o_frame_ovf`=1.
- **Simultaneous events:** zero and strobe in the same cycle with the offset changed 100→200, raw 700 → idx 0, data 500, and the previous `o_frame_pts` excludes the sample.
- **Pre-zero and reset:** strobes before the first zero → no valid. Reset asserted during a back-to-back burst → all outputs 0 next cycle, no valid until the next zero plus strobe.

Source files
------------

// File: rtl/ms1205_pkg.sv
// Shared types and constants for the MS1205 rise-time framer.
package ms1205_pkg;

  typedef enum logic [1:0] {
    FLAG_OK     = 2'b00,
    FLAG_NOECHO = 2'b01,
    FLAG_CLAMP  = 2'b10,
    FLAG_TDCERR = 2'b11
  } dist_flag_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitZero = 2'd1,
    StRun      = 2'd2
  } frame_state_e;

  localparam logic [15:0] NO_ECHO = 16'hFFFF;

endpackage

// File: rtl/ms1205_rise_correct.sv
// Two-stage correction pipeline: stage 1 captures the sample with its frame context,
// stage 2 subtracts the offset, clamps, flags and registers the result.
module ms1205_rise_correct
  import ms1205_pkg::*;
#(
  parameter int unsigned IDX_W = 12
) (
  input  logic             i_clk_50m,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [15:0]      i_raw,
  input  logic             i_err,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [15:0]      i_offset,
  input  logic [15:0]      i_dist_max,
  output logic [15:0]      o_data,
  output logic [IDX_W-1:0] o_idx,
  output logic [1:0]       o_flag,
  output logic             o_valid
);

  logic             s1_valid_q;
  logic [15:0]      s1_raw_q;
  logic             s1_err_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [15:0]      s1_off_q;
  logic [15:0]      s1_max_q;

  logic [16:0]      diff;
  logic [15:0]      data_d;
  dist_flag_e       flag_d;

  logic             valid_q;
  logic [15:0]      data_q;
  logic [IDX_W-1:0] idx_q;
  dist_flag_e       flag_q;

  // Offset and clamp travel with the sample so in-flight points keep their frame's settings.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_err_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_off_q   <= '0;
      s1_max_q   <= '0;
    end else begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_raw_q <= i_raw;
        s1_err_q <= i_err;
        s1_idx_q <= i_idx;
        s1_off_q <= i_offset;
        s1_max_q <= i_dist_max;
      end
    end
  end

  always_comb begin
    diff   = {1'b0, s1_raw_q} - {1'b0, s1_off_q};
    data_d = diff[15:0];
    flag_d = FLAG_OK;
    if (s1_err_q) begin
      data_d = NO_ECHO;
      flag_d = FLAG_TDCERR;
    end else if (s1_raw_q == NO_ECHO) begin
      data_d = NO_ECHO;
      flag_d = FLAG_NOECHO;
    end else if (diff[16]) begin
      data_d = '0;
    end else if (diff[15:0] > s1_max_q) begin
      data_d = s1_max_q;
      flag_d = FLAG_CLAMP;
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      flag_q  <= FLAG_OK;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q <= data_d;
        idx_q  <= s1_idx_q;
        flag_q <= flag_d;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_idx   = idx_q;
  assign o_flag  = flag_q;

endmodule

// File: rtl/ms1205_rise_framer.sv
// Frames TDC rise samples between revolution-start pulses, indexes them and publishes
// per-frame point, miss and overflow statistics.
module ms1205_rise_framer
  import ms1205_pkg::*;
#(
  parameter int unsigned MAX_PTS = 1800,
  parameter int unsigned IDX_W   = 12
) (
  input  logic             i_clk_50m,
  input  logic             i_rst,
  input  logic             i_zero_sig,
  input  logic             i_tdc_new_sig,
  input  logic [15:0]      i_rise_data,
  input  logic             i_tdc_err_sig,
  input  logic [15:0]      i_zero_offset,
  input  logic [15:0]      i_dist_max,
  output logic [15:0]      o_dist_data,
  output logic [IDX_W-1:0] o_dist_idx,
  output logic [1:0]       o_dist_flag,
  output logic             o_dist_valid,
  output logic             o_frame_done,
  output logic [IDX_W-1:0] o_frame_pts,
  output logic [15:0]      o_frame_miss,
  output logic             o_frame_ovf
);

  localparam logic [IDX_W-1:0] MaxPts = IDX_W'(MAX_PTS);

  frame_state_e     state_q;
  logic [15:0]      offset_q;
  logic [15:0]      dist_max_q;
  logic [IDX_W-1:0] cnt_q;
  logic [15:0]      miss_q;
  logic             ovf_q;

  logic             frame_done_q;
  logic [IDX_W-1:0] frame_pts_q;
  logic [15:0]      frame_miss_q;
  logic             frame_ovf_q;

  logic             frame_start;
  logic             frame_end;
  logic             accept;
  logic             no_echo;
  logic             drop;
  logic [IDX_W-1:0] cnt_eff;
  logic [15:0]      offset_eff;
  logic [15:0]      max_eff;

  // A strobe coinciding with a zero pulse belongs to the new frame: index 0, new settings.
  always_comb begin
    frame_start = i_zero_sig && (state_q == StWaitZero || state_q == StRun);
    frame_end   = i_zero_sig && (state_q == StRun);
    cnt_eff     = frame_start ? '0 : cnt_q;
    offset_eff  = frame_start ? i_zero_offset : offset_q;
    max_eff     = frame_start ? i_dist_max : dist_max_q;
    accept      = i_tdc_new_sig && (frame_start || state_q == StRun) && (cnt_eff < MaxPts);
    drop        = i_tdc_new_sig && (state_q == StRun) && !frame_start && !accept;
    no_echo     = accept && !i_tdc_err_sig && (i_rise_data == NO_ECHO);
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_q      <= StIdle;
      offset_q     <= '0;
      dist_max_q   <= 16'hFFFF;
      cnt_q        <= '0;
      miss_q       <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_pts_q  <= '0;
      frame_miss_q <= '0;
      frame_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle:     state_q <= StWaitZero;
        StWaitZero: if (i_zero_sig) state_q <= StRun;
        StRun:      state_q <= StRun;
        default:    state_q <= StIdle;
      endcase

      frame_done_q <= frame_end;
      if (frame_end) begin
        frame_pts_q  <= cnt_q;
        frame_miss_q <= miss_q;
        frame_ovf_q  <= ovf_q;
      end

      if (frame_start) begin
        offset_q   <= i_zero_offset;
        dist_max_q <= i_dist_max;
      end

      if (accept) begin
        cnt_q <= cnt_eff + IDX_W'(1);
      end else if (frame_start) begin
        cnt_q <= '0;
      end

      if (frame_start) begin
        miss_q <= {15'd0, no_echo};
      end else if (no_echo && miss_q != 16'hFFFF) begin
        miss_q <= miss_q + 16'd1;
      end

      if (frame_start) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  ms1205_rise_correct #(
    .IDX_W(IDX_W)
  ) u_correct (
    .i_clk_50m (i_clk_50m),
    .i_rst     (i_rst),
    .i_valid   (accept),
    .i_raw     (i_rise_data),
    .i_err     (i_tdc_err_sig),
    .i_idx     (cnt_eff),
    .i_offset  (offset_eff),
    .i_dist_max(max_eff),
    .o_data    (o_dist_data),
    .o_idx     (o_dist_idx),
    .o_flag    (o_dist_flag),
    .o_valid   (o_dist_valid)
  );

  assign o_frame_done = frame_done_q;
  assign o_frame_pts  = frame_pts_q;
  assign o_frame_miss = frame_miss_q;
  assign o_frame_ovf  = frame_ovf_q;

endmodule

// File: tb/tb_ms1205_rise_framer.sv
// Bench for ms1205_rise_framer: directed scenarios plus randomized frames checked against
// a sample-level reference model.
module tb_ms1205_rise_framer;

  localparam int MAX_PTS = 4;
  localparam int IDX_W   = 12;

  logic             i_clk_50m = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_zero_sig = 1'b0;
  logic             i_tdc_new_sig = 1'b0;
  logic [15:0]      i_rise_data = '0;
  logic             i_tdc_err_sig = 1'b0;
  logic [15:0]      i_zero_offset = '0;
  logic [15:0]      i_dist_max = '0;
  logic [15:0]      o_dist_data;
  logic [IDX_W-1:0] o_dist_idx;
  logic [1:0]       o_dist_flag;
  logic             o_dist_valid;
  logic             o_frame_done;
  logic [IDX_W-1:0] o_frame_pts;
  logic [15:0]      o_frame_miss;
  logic             o_frame_ovf;

  ms1205_rise_framer #(
    .MAX_PTS(MAX_PTS),
    .IDX_W  (IDX_W)
  ) dut (
    .i_clk_50m    (i_clk_50m),
    .i_rst        (i_rst),
    .i_zero_sig   (i_zero_sig),
    .i_tdc_new_sig(i_tdc_new_sig),
    .i_rise_data  (i_rise_data),
    .i_tdc_err_sig(i_tdc_err_sig),
    .i_zero_offset(i_zero_offset),
    .i_dist_max   (i_dist_max),
    .o_dist_data  (o_dist_data),
    .o_dist_idx   (o_dist_idx),
    .o_dist_flag  (o_dist_flag),
    .o_dist_valid (o_dist_valid),
    .o_frame_done (o_frame_done),
    .o_frame_pts  (o_frame_pts),
    .o_frame_miss (o_frame_miss),
    .o_frame_ovf  (o_frame_ovf)
  );

  always #10 i_clk_50m = ~i_clk_50m;

  int unsigned cyc = 0;
  always @(posedge i_clk_50m) cyc <= cyc + 1;

  typedef struct {
    int unsigned      cyc;
    logic [15:0]      data;
    logic [IDX_W-1:0] idx;
    logic [1:0]       flag;
  } dist_t;

  typedef struct {
    int unsigned      cyc;
    logic [IDX_W-1:0] pts;
    logic [15:0]      miss;
    logic             ovf;
  } frame_t;

  dist_t  obs_v[$];
  dist_t  exp_v[$];
  frame_t obs_f[$];
  frame_t exp_f[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: is a frame open, and what has it seen so far.
  bit m_run = 0;
  int m_cnt = 0;
  int m_miss = 0;
  bit m_ovf = 0;
  int m_off = 0;
  int m_max = 65535;

  dist_t  col_d;
  frame_t col_f;
  always @(negedge i_clk_50m) begin
    if (o_dist_valid === 1'b1) begin
      col_d.cyc = cyc; col_d.data = o_dist_data; col_d.idx = o_dist_idx; col_d.flag = o_dist_flag;
      obs_v.push_back(col_d);
    end
    if (o_frame_done === 1'b1) begin
      col_f.cyc = cyc; col_f.pts = o_frame_pts; col_f.miss = o_frame_miss; col_f.ovf = o_frame_ovf;
      obs_f.push_back(col_f);
    end
  end

  function automatic void ref_correct(input int raw, input bit err, input int off, input int mx,
                                      output int d, output int fl);
    if (err) begin
      d = 65535; fl = 3;
    end else if (raw == 65535) begin
      d = 65535; fl = 1;
    end else if (raw < off) begin
      d = 0; fl = 0;
    end else if (raw - off > mx) begin
      d = mx; fl = 2;
    end else begin
      d = raw - off; fl = 0;
    end
  endfunction

  // Present one cycle of stimulus and advance the model by one cycle.
  task automatic step(input bit z, input bit s, input int raw, input bit err, input int off,
                      input int mx);
    dist_t  e;
    frame_t fr;
    int     d;
    int     fl;
    i_zero_sig = z; i_tdc_new_sig = s; i_rise_data = 16'(raw); i_tdc_err_sig = err;
    i_zero_offset = 16'(off); i_dist_max = 16'(mx);
    if (z) begin
      if (m_run) begin
        fr.cyc = cyc + 1; fr.pts = IDX_W'(m_cnt); fr.miss = 16'(m_miss); fr.ovf = m_ovf;
        exp_f.push_back(fr);
      end
      m_run = 1; m_off = off; m_max = mx; m_cnt = 0; m_miss = 0; m_ovf = 0;
    end
    if (s && m_run) begin
      if (m_cnt < MAX_PTS) begin
        ref_correct(raw, err, m_off, m_max, d, fl);
        e.cyc = cyc + 2; e.data = 16'(d); e.idx = IDX_W'(m_cnt); e.flag = 2'(fl);
        exp_v.push_back(e);
        m_cnt++;
        if (!err && raw == 65535 && m_miss < 65535) m_miss++;
      end else begin
        m_ovf = 1;
      end
    end
    @(posedge i_clk_50m);
    #1;
    i_zero_sig = 0; i_tdc_new_sig = 0; i_tdc_err_sig = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_all();
    obs_v.delete(); exp_v.delete(); obs_f.delete(); exp_f.delete();
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_miss = 0; m_ovf = 0; m_off = 0; m_max = 65535;
  endtask

  task automatic test_reset();
    i_rst = 1;
    repeat (2) @(posedge i_clk_50m);
    #1;
    checks++; if (o_dist_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_dist_valid); end
    checks++; if (o_dist_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %h want 0", o_dist_data); end
    checks++; if (o_dist_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", o_dist_idx); end
    checks++; if (o_dist_flag !== 2'b00) begin errors++; $display("FAIL reset_flag: got %b want 00", o_dist_flag); end
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_frame_done); end
    checks++; if (o_frame_pts !== '0) begin errors++; $display("FAIL reset_pts: got %0d want 0", o_frame_pts); end
    checks++; if (o_frame_miss !== 16'd0) begin errors++; $display("FAIL reset_miss: got %0d want 0", o_frame_miss); end
    checks++; if (o_frame_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_frame_ovf); end
    i_rst = 0;
    model_reset();
    idle(2);
    clear_all();
  endtask

  task automatic test_pre_zero();
    clear_all();
    for (int i = 0; i < 5; i++) step(0, 1, 100 + i, 0, 0, 0);
    idle(4);
    checks++;
    if (obs_v.size() != 0) begin
      errors++; $display("FAIL pre_zero_valids: got %0d want 0", obs_v.size());
    end
  endtask

  task automatic test_basic();
    int          want_d[3];
    int          want_f[3];
    int unsigned sc[3];
    int          raws[3];
    want_d = '{1000, 0, 5000};
    want_f = '{0, 0, 2};
    raws   = '{1100, 50, 6000};
    clear_all();
    step(1, 0, 0, 0, 100, 5000);
    for (int i = 0; i < 3; i++) begin
      sc[i] = cyc;
      step(0, 1, raws[i], 0, 0, 0);
    end
    idle(4);
    checks++;
    if (obs_v.size() != 3) begin
      errors++; $display("FAIL basic_count: got %0d want 3", obs_v.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_v[i].data !== 16'(want_d[i]) || obs_v[i].flag !== 2'(want_f[i]) ||
            obs_v[i].idx !== IDX_W'(i) || obs_v[i].cyc !== sc[i] + 2) begin
          errors++;
          $display("FAIL basic_pt%0d: got data %0d flag %b idx %0d cyc %0d want %0d %b %0d %0d", i,
                   obs_v[i].data, obs_v[i].flag, obs_v[i].idx, obs_v[i].cyc, want_d[i],
                   2'(want_f[i]), i, sc[i] + 2);
        end
      end
    end
  endtask

  task automatic test_noecho_err();
    int unsigned zc;
    clear_all();
    step(1, 0, 0, 0, 100, 5000);
    step(0, 1, 65535, 0, 0, 0);
    step(0, 1, 500, 1, 0, 0);
    zc = cyc;
    step(1, 0, 0, 0, 100, 5000);
    idle(4);
    checks++;
    if (obs_v.size() != 2) begin
      errors++; $display("FAIL noecho_count: got %0d want 2", obs_v.size());
    end else begin
      checks++;
      if (obs_v[0].data !== 16'hFFFF || obs_v[0].flag !== 2'b01) begin
        errors++; $display("FAIL noecho_pt: got %h/%b want ffff/01", obs_v[0].data, obs_v[0].flag);
      end
      checks++;
      if (obs_v[1].data !== 16'hFFFF || obs_v[1].flag !== 2'b11 || obs_v[1].idx !== IDX_W'(1)) begin
        errors++;
        $display("FAIL tdcerr_pt: got %h/%b idx %0d want ffff/11 idx 1", obs_v[1].data,
                 obs_v[1].flag, obs_v[1].idx);
      end
    end
    checks++;
    if (obs_f.size() != 2) begin
      errors++; $display("FAIL noecho_frames: got %0d want 2", obs_f.size());
    end else begin
      checks++;
      if (obs_f[1].miss !== 16'd1 || obs_f[1].pts !== IDX_W'(2) || obs_f[1].ovf !== 1'b0 ||
          obs_f[1].cyc !== zc + 1) begin
        errors++;
        $display("FAIL noecho_stats: got miss %0d pts %0d ovf %b cyc %0d want 1 2 0 %0d",
                 obs_f[1].miss, obs_f[1].pts, obs_f[1].ovf, obs_f[1].cyc, zc + 1);
      end
    end
  endtask

  task automatic test_overflow();
    clear_all();
    step(1, 0, 0, 0, 0, 60000);
    for (int i = 0; i < 6; i++) step(0, 1, 200 + i * 10, 0, 0, 0);
    step(1, 0, 0, 0, 0, 60000);
    idle(4);
    checks++;
    if (obs_v.size() != MAX_PTS) begin
      errors++; $display("FAIL ovf_count: got %0d want %0d", obs_v.size(), MAX_PTS);
    end else begin
      for (int i = 0; i < MAX_PTS; i++) begin
        checks++;
        if (obs_v[i].idx !== IDX_W'(i) || obs_v[i].data !== 16'(200 + i * 10)) begin
          errors++;
          $display("FAIL ovf_pt%0d: got idx %0d data %0d want %0d %0d", i, obs_v[i].idx,
                   obs_v[i].data, i, 200 + i * 10);
        end
      end
    end
    checks++;
    if (obs_f.size() != 2) begin
      errors++; $display("FAIL ovf_frames: got %0d want 2", obs_f.size());
    end else begin
      checks++;
      if (obs_f[1].pts !== IDX_W'(MAX_PTS) || obs_f[1].ovf !== 1'b1) begin
        errors++;
        $display("FAIL ovf_stats: got pts %0d ovf %b want %0d 1", obs_f[1].pts, obs_f[1].ovf,
                 MAX_PTS);
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_all();
    step(1, 0, 0, 0, 100, 5000);
    step(0, 1, 300, 0, 0, 0);
    step(1, 1, 700, 0, 200, 5000);
    idle(4);
    checks++;
    if (obs_v.size() != 2) begin
      errors++; $display("FAIL simul_count: got %0d want 2", obs_v.size());
    end else begin
      checks++;
      if (obs_v[0].data !== 16'd200 || obs_v[0].idx !== IDX_W'(0)) begin
        errors++; $display("FAIL simul_inflight: got %0d idx %0d want 200 idx 0", obs_v[0].data, obs_v[0].idx);
      end
      checks++;
      if (obs_v[1].data !== 16'd500 || obs_v[1].idx !== IDX_W'(0) || obs_v[1].flag !== 2'b00) begin
        errors++; $display("FAIL simul_new: got %0d idx %0d want 500 idx 0", obs_v[1].data, obs_v[1].idx);
      end
    end
    checks++;
    if (obs_f.size() != 2) begin
      errors++; $display("FAIL simul_frames: got %0d want 2", obs_f.size());
    end else begin
      checks++;
      if (obs_f[1].pts !== IDX_W'(1)) begin
        errors++; $display("FAIL simul_pts: got %0d want 1", obs_f[1].pts);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int raw;
    clear_all();
    for (int i = 0; i < 600; i++) begin
      raw = ($urandom_range(0, 9) == 0) ? 65535 : int'($urandom_range(0, 65534));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, raw, $urandom_range(0, 19) == 0,
           int'($urandom_range(0, 20000)), int'($urandom_range(0, 40000)));
    end
    idle(4);
    checks++;
    if (obs_v.size() != exp_v.size()) begin
      errors++; $display("FAIL rand_valid_count: got %0d want %0d", obs_v.size(), exp_v.size());
    end
    n = (obs_v.size() < exp_v.size()) ? obs_v.size() : exp_v.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_v[i].cyc !== exp_v[i].cyc || obs_v[i].data !== exp_v[i].data ||
          obs_v[i].idx !== exp_v[i].idx || obs_v[i].flag !== exp_v[i].flag) begin
        errors++;
        $display("FAIL rand_pt%0d: got cyc %0d data %h idx %0d flag %b want %0d %h %0d %b", i,
                 obs_v[i].cyc, obs_v[i].data, obs_v[i].idx, obs_v[i].flag, exp_v[i].cyc,
                 exp_v[i].data, exp_v[i].idx, exp_v[i].flag);
      end
    end
    checks++;
    if (obs_f.size() != exp_f.size()) begin
      errors++; $display("FAIL rand_frame_count: got %0d want %0d", obs_f.size(), exp_f.size());
    end
    n = (obs_f.size() < exp_f.size()) ? obs_f.size() : exp_f.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_f[i].cyc !== exp_f[i].cyc || obs_f[i].pts !== exp_f[i].pts ||
          obs_f[i].miss !== exp_f[i].miss || obs_f[i].ovf !== exp_f[i].ovf) begin
        errors++;
        $display("FAIL rand_frame%0d: got cyc %0d pts %0d miss %0d ovf %b want %0d %0d %0d %b", i,
                 obs_f[i].cyc, obs_f[i].pts, obs_f[i].miss, obs_f[i].ovf, exp_f[i].cyc,
                 exp_f[i].pts, exp_f[i].miss, exp_f[i].ovf);
      end
    end
  endtask

  task automatic test_reset_burst();
    clear_all();
    step(1, 0, 0, 0, 100, 5000);
    step(0, 1, 1000, 0, 0, 0);
    step(0, 1, 1500, 0, 0, 0);
    step(0, 1, 2000, 0, 0, 0);
    i_rst = 1; i_tdc_new_sig = 1; i_rise_data = 16'd2500;
    @(posedge i_clk_50m);
    #1;
    checks++;
    if (o_dist_valid !== 1'b0 || o_dist_data !== 16'd0 || o_dist_idx !== '0 || o_dist_flag !== 2'b00) begin
      errors++;
      $display("FAIL burst_reset_dist: got v %b data %0d idx %0d flag %b want all 0", o_dist_valid,
               o_dist_data, o_dist_idx, o_dist_flag);
    end
    checks++;
    if (o_frame_done !== 1'b0 || o_frame_pts !== '0 || o_frame_miss !== 16'd0 || o_frame_ovf !== 1'b0) begin
      errors++;
      $display("FAIL burst_reset_frame: got done %b pts %0d miss %0d ovf %b want all 0",
               o_frame_done, o_frame_pts, o_frame_miss, o_frame_ovf);
    end
    i_rst = 0; i_tdc_new_sig = 0;
    model_reset();
    idle(2);
    clear_all();
    for (int i = 0; i < 3; i++) step(0, 1, 900, 0, 0, 0);
    idle(3);
    checks++;
    if (obs_v.size() != 0) begin
      errors++; $display("FAIL burst_post_reset: got %0d valids want 0", obs_v.size());
    end
    step(1, 1, 700, 0, 200, 5000);
    idle(3);
    checks++;
    if (obs_v.size() != 1) begin
      errors++; $display("FAIL burst_restart_count: got %0d want 1", obs_v.size());
    end else begin
      checks++;
      if (obs_v[0].data !== 16'd500 || obs_v[0].idx !== IDX_W'(0)) begin
        errors++;
        $display("FAIL burst_restart_pt: got %0d idx %0d want 500 idx 0", obs_v[0].data, obs_v[0].idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pre_zero();
    test_basic();
    test_noecho_err();
    test_overflow();
    test_simultaneous();
    test_random();
    test_reset_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
